conv_loop_sequencer: RTL

- Single-clock scheduler for the convolution datapath: input-feature buffer, weight buffer, 4-lane muladd, accumulator, output buffer.
- Walks the loop nest m→r→c→n→i→j. Issues one read per cycle to the ifm and weight buffers.
- Generates delay-aligned accumulator clear/enable and output write strobes and addresses.
- Launched by a start/done handshake. Configuration is latched at start.

---
 rtl/conv_loop_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/conv_loop_sequencer.sv
// Loop-nest scheduler for the convolution datapath: walks m->r->c->n->i->j, issues buffer
// reads and produces delay-aligned accumulator and output-write strobes.
module conv_loop_sequencer #(
    parameter int AW      = 16,
    parameter int CW      = 8,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    input  logic [CW-1:0] cfg_m,
    input  logic [CW-1:0] cfg_r,
    input  logic [CW-1:0] cfg_c,
    input  logic [CW-1:0] cfg_n,
    input  logic [3:0]    cfg_k,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] ifm_addr,
    output logic [AW-1:0] weight_addr,
    output logic          acc_clear,
    output logic          acc_en,
    output logic          out_wr_en,
    output logic [AW-1:0] out_addr,
    output logic          cfg_err
);
    localparam int unsigned D = RD_LAT + MAC_LAT;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic          valid;
        logic          first;
        logic          last;
        logic [AW-1:0] oaddr;
    } tag_t;

    state_t        state, state_nx;
    logic [CW-1:0] lm, lr, lc, ln;
    logic [3:0]    lk;
    logic [CW-1:0] m, r, c, n;
    logic [3:0]    i, j;
    tag_t          tags [0:D];
    tag_t          tag_nx;
    logic          err_pulse;
    logic          cfg_bad, issue, pipe_busy;
    logic          j_end, i_end, n_end, c_end, r_end, m_end, last_tuple;
    logic [AW-1:0] ih, iw, ifm_nx, weight_nx;

    assign cfg_bad = (cfg_m == '0) || (cfg_r == '0) || (cfg_c == '0) ||
                     (cfg_n == '0) || (cfg_k == '0);

    always_comb begin
        j_end      = (j == lk - 4'd1);
        i_end      = (i == lk - 4'd1);
        n_end      = (n == ln - CW'(1));
        c_end      = (c == lc - CW'(1));
        r_end      = (r == lr - CW'(1));
        m_end      = (m == lm - CW'(1));
        last_tuple = j_end && i_end && n_end && c_end && r_end && m_end;
        issue      = (state == RUN) && !hold;

        ih        = AW'(lr) + AW'(lk) - AW'(1);
        iw        = AW'(lc) + AW'(lk) - AW'(1);
        ifm_nx    = (AW'(n) * ih + AW'(r) + AW'(i)) * iw + AW'(c) + AW'(j);
        weight_nx = ((AW'(m) * AW'(ln) + AW'(n)) * AW'(lk) + AW'(i)) * AW'(lk) + AW'(j);

        tag_nx.valid = issue;
        tag_nx.first = (n == '0) && (i == '0) && (j == '0);
        tag_nx.last  = n_end && i_end && j_end;
        tag_nx.oaddr = (AW'(m) * AW'(lr) + AW'(r)) * AW'(lc) + AW'(c);

        pipe_busy = 1'b0;
        for (int unsigned k = 0; k <= D; k++) begin
            pipe_busy = pipe_busy | tags[k].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // DRAIN exits once the final tag has left the pipe and its write strobe is on the output.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !cfg_bad) state_nx = RUN;
            RUN:     if (issue && last_tuple) state_nx = DRAIN;
            DRAIN:   if (!pipe_busy && out_wr_en) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {lm, lr, lc, ln, lk} <= '0;
            {m, r, c, n, i, j}   <= '0;
            rd_en       <= 1'b0;
            ifm_addr    <= '0;
            weight_addr <= '0;
            out_wr_en   <= 1'b0;
            out_addr    <= '0;
            cfg_err     <= 1'b0;
            err_pulse   <= 1'b0;
            for (int unsigned k = 0; k <= D; k++) tags[k] <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (state == IDLE && start) begin
                lm <= cfg_m; lr <= cfg_r; lc <= cfg_c; ln <= cfg_n; lk <= cfg_k;
                {m, r, c, n, i, j} <= '0;
                cfg_err   <= cfg_bad;
                err_pulse <= cfg_bad;
            end
            rd_en <= issue;
            if (issue) begin
                ifm_addr    <= ifm_nx;
                weight_addr <= weight_nx;
                if (!j_end) j <= j + 4'd1;
                else begin
                    j <= '0;
                    if (!i_end) i <= i + 4'd1;
                    else begin
                        i <= '0;
                        if (!n_end) n <= n + CW'(1);
                        else begin
                            n <= '0;
                            if (!c_end) c <= c + CW'(1);
                            else begin
                                c <= '0;
                                if (!r_end) r <= r + CW'(1);
                                else begin
                                    r <= '0;
                                    m <= m_end ? '0 : m + CW'(1);
                                end
                            end
                        end
                    end
                end
            end
            tags[0] <= tag_nx;
            for (int unsigned k = 1; k <= D; k++) tags[k] <= tags[k-1];
            out_wr_en <= tags[D].valid && tags[D].last;
            if (tags[D].valid && tags[D].last) out_addr <= tags[D].oaddr;
        end
    end

    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE) || err_pulse;
    assign acc_en    = tags[D].valid;
    assign acc_clear = tags[D].valid && tags[D].first;
endmodule
